// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encodings and the single-cycle ALU datapath function.
// Latency: purely combinational helpers; no state lives here.
// Backpressure: none; callers own the valid/ready handshake.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_LUI  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1010;
  localparam logic [3:0] OP_BNE  = 4'b1110;
  localparam logic [3:0] OP_SLTU = 4'b1111;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  // Widest datapath the single-cycle function supports; narrower units zero-extend.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic [MAX_W-1:0] res;
    logic             zero;
    logic             ovf;
  } sc_res_t;

  // Single-cycle result for a w-bit datapath; operands arrive zero-extended to MAX_W.
  function automatic sc_res_t alu_single(input logic [3:0] op, input logic [MAX_W-1:0] a,
                                         input logic [MAX_W-1:0] b, input logic [5:0] shamt,
                                         input int w);
    sc_res_t          o;
    logic [MAX_W-1:0] mask;
    logic [MAX_W-1:0] msb;
    logic [MAX_W-1:0] r;
    logic             sa;
    logic             sb;
    logic             sr;
    mask = (w >= MAX_W) ? '1 : ((64'd1 << w) - 64'd1);
    msb  = 64'd1 << (w - 1);
    sa   = |(a & msb);
    sb   = |(b & msb);
    r    = '0;
    case (op)
      OP_AND:         r = a & b;
      OP_OR:          r = a | b;
      OP_ADD:         r = (a + b) & mask;
      OP_SLL:         r = (b << shamt) & mask;
      OP_LUI:         r = (b << (w / 2)) & mask;
      OP_SRL:         r = b >> shamt;
      OP_SUB, OP_BNE: r = (a - b) & mask;
      OP_SLT:         r[0] = (sa != sb) ? sa : (a < b);
      OP_SLTU:        r[0] = (a < b);
      default:        r = '0;
    endcase
    sr    = |(r & msb);
    o.res = r;
    o.ovf = 1'b0;
    if (op == OP_ADD) o.ovf = (sa == sb) && (sr != sa);
    if (op == OP_SUB || op == OP_BNE) o.ovf = (sa != sb) && (sr != sa);
    // BNE reports "taken" on zero_o, i.e. the operands differ.
    o.zero = (op == OP_BNE) ? (r != '0) : (r == '0);
    return o;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative unsigned multiplier (shift-add) and restoring divider sharing one 2*WIDTH accumulator.
// Latency: WIDTH iterations; first on the start edge, done_o flags the edge performing the last.
// Backpressure: none; the owner must not pulse start_i while an operation is in flight.
module alu_iter_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             mode_i,   // 0: multiply, 1: divide
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] lo_o,     // product low / quotient
  output logic [WIDTH-1:0] hi_o      // product high / remainder
);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_src, acc_step;
  logic [WIDTH-1:0]   opb_q, opb_d, opb_src;
  logic               mode_q, mode_d, mode_src;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     trial;
  logic               ge;

  // Pick iteration source (fresh operands on start, else held state) and compute one step.
  always_comb begin
    cnt_d    = cnt_q;
    opb_d    = opb_q;
    mode_d   = mode_q;
    acc_src  = acc_q;
    opb_src  = opb_q;
    mode_src = mode_q;
    if (start_i) begin
      // Multiplier and dividend both start in the low half with the upper half cleared.
      acc_src  = {{WIDTH{1'b0}}, a_i};
      opb_src  = b_i;
      mode_src = mode_i;
      opb_d    = b_i;
      mode_d   = mode_i;
      cnt_d    = CNT_W'(WIDTH);
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
    sum   = {1'b0, acc_src[2*WIDTH-1:WIDTH]} + (acc_src[0] ? {1'b0, opb_src} : '0);
    trial = {acc_src[2*WIDTH-1:WIDTH], acc_src[WIDTH-1]};
    ge    = (trial >= {1'b0, opb_src});
    if (mode_src) begin
      acc_step = {(ge ? WIDTH'(trial - {1'b0, opb_src}) : trial[WIDTH-1:0]),
                  acc_src[WIDTH-2:0], ge};
    end else begin
      acc_step = {sum, acc_src[WIDTH-1:1]};
    end
    acc_d = (start_i || cnt_q > CNT_W'(1)) ? acc_step : acc_q;
  end

  assign done_o = (cnt_q == CNT_W'(2));
  assign lo_o   = acc_d[WIDTH-1:0];
  assign hi_o   = acc_d[2*WIDTH-1:WIDTH];

  // Iteration state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      opb_q  <= '0;
      mode_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/arith/shift/compare plus iterative MUL/DIVU/REMU.
// Latency: 1 cycle for single-cycle ops and divide-by-zero, WIDTH cycles for MUL/DIVU/REMU.
// Backpressure: ready_o low while an iterative op runs; requests then are dropped, not buffered.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic [3:0]       ctrl_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             ovf_o
);

  localparam int SH_W = $clog2(WIDTH);

  logic [1:0]       state_q, state_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             md_start, md_mode, md_done;
  logic [WIDTH-1:0] md_lo, md_hi;
  logic [MAX_W-1:0] a_ext, b_ext;
  logic [5:0]       shamt;
  sc_res_t          sc;

  alu_iter_muldiv #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_muldiv (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .start_i(md_start),
    .mode_i (md_mode),
    .a_i    (src1_i),
    .b_i    (src2_i),
    .done_o (md_done),
    .lo_o   (md_lo),
    .hi_o   (md_hi)
  );

  if (WIDTH < MAX_W) begin : g_pad
    logic pad_unused;
    assign pad_unused = ^sc.res[MAX_W-1:WIDTH];
  end

  // Single-cycle datapath on the live request operands.
  always_comb begin
    a_ext              = '0;
    b_ext              = '0;
    shamt              = '0;
    a_ext[WIDTH-1:0]   = src1_i;
    b_ext[WIDTH-1:0]   = src2_i;
    shamt[SH_W-1:0]    = src1_i[SH_W-1:0];
    sc                 = alu_single(ctrl_i, a_ext, b_ext, shamt, WIDTH);
  end

  // Control FSM: accept in IDLE, launch the iterator, capture results on completion.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    md_start = 1'b0;
    md_mode  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          op_d = ctrl_i;
          if (ctrl_i == OP_MUL) begin
            md_start = 1'b1;
            state_d  = S_MUL;
          end else if (ctrl_i == OP_DIVU || ctrl_i == OP_REMU) begin
            if (src2_i == '0) begin
              // Divide by zero resolves immediately without iterating.
              result_d = (ctrl_i == OP_DIVU) ? '1 : src1_i;
              zero_d   = (result_d == '0);
              ovf_d    = 1'b1;
              valid_d  = 1'b1;
            end else begin
              md_start = 1'b1;
              md_mode  = 1'b1;
              state_d  = S_DIV;
            end
          end else begin
            result_d = sc.res[WIDTH-1:0];
            zero_d   = sc.zero;
            ovf_d    = sc.ovf;
            valid_d  = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (md_done) begin
          result_d = md_lo;
          zero_d   = (md_lo == '0);
          ovf_d    = |md_hi;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      S_DIV: begin
        if (md_done) begin
          result_d = (op_q == OP_REMU) ? md_hi : md_lo;
          zero_d   = (result_d == '0);
          ovf_d    = 1'b0;
          valid_d  = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered state and outputs; reset aborts any op in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= OP_AND;
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
    end
  end

  assign ready_o  = (state_q == S_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: directed requests push expected results, a monitor checks them.
// Latency: expected valid_o cycle is tracked per request and compared by the monitor.
// Backpressure: requests wait (bounded) for ready_o before being driven.
module tb_alu_seq;

  localparam int W = 32;

  localparam logic [3:0] C_AND  = 4'b0000;
  localparam logic [3:0] C_OR   = 4'b0001;
  localparam logic [3:0] C_ADD  = 4'b0010;
  localparam logic [3:0] C_SLL  = 4'b0011;
  localparam logic [3:0] C_LUI  = 4'b0100;
  localparam logic [3:0] C_SRL  = 4'b0101;
  localparam logic [3:0] C_SUB  = 4'b0110;
  localparam logic [3:0] C_SLT  = 4'b0111;
  localparam logic [3:0] C_MUL  = 4'b1000;
  localparam logic [3:0] C_DIVU = 4'b1001;
  localparam logic [3:0] C_REMU = 4'b1010;
  localparam logic [3:0] C_RSV  = 4'b1100;
  localparam logic [3:0] C_BNE  = 4'b1110;
  localparam logic [3:0] C_SLTU = 4'b1111;

  logic         clk = 1'b0;
  logic         rst_i = 1'b1;
  logic         valid_i = 1'b0;
  logic         ready_o;
  logic [W-1:0] src1_i = '0;
  logic [W-1:0] src2_i = '0;
  logic [3:0]   ctrl_i = '0;
  logic         valid_o;
  logic [W-1:0] result_o;
  logic         zero_o;
  logic         ovf_o;

  alu_seq #(.WIDTH(W)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .src1_i  (src1_i),
    .src2_i  (src2_i),
    .ctrl_i  (ctrl_i),
    .valid_o (valid_o),
    .result_o(result_o),
    .zero_o  (zero_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every valid_o pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_i && valid_o) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", result_o, e.res);
        chk("zero", {31'd0, zero_o}, {31'd0, e.zero});
        chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  // Drive one request once ready; optionally record its expected response.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ez, input logic eo,
                       input int lat, input bit push);
    exp_t e;
    int   k = 0;
    @(negedge clk);
    while (!ready_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ready_o) chk("ready_timeout", 32'd0, 32'd1);
    ctrl_i  = op;
    src1_i  = a;
    src2_i  = b;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    if (push) begin
      e.res  = er;
      e.zero = ez;
      e.ovf  = eo;
      e.cyc  = cyc + lat - 1;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_result", result_o, 32'd0);
    chk("rst_zero", {31'd0, zero_o}, 32'd0);
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);

    // 1: ADD overflow, then back-to-back SUB to zero
    issue(C_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b1, 1, 1'b1);
    issue(C_SUB, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1, 1'b1);
    issue(C_SUB, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 1'b1, 1, 1'b1);
    issue(C_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1'b0, 1'b0, 1, 1'b1);
    issue(C_OR, 32'hF000_0000, 32'h0000_000F, 32'hF000_000F, 1'b0, 1'b0, 1, 1'b1);
    issue(C_RSV, 32'h1234, 32'h5678, 32'd0, 1'b1, 1'b0, 1, 1'b1);

    // 2: MUL with overflow, ready low for WIDTH-1 cycles
    issue(C_MUL, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b1, 1'b1, 32, 1'b1);
    n = 0;
    @(negedge clk);
    while (!ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("mul_ready_low_cycles", n, 32'd31);
    issue(C_MUL, 32'd1234, 32'd5678, 32'd7006652, 1'b0, 1'b0, 32, 1'b1);

    // 3: divide / remainder, including divide by zero
    issue(C_DIVU, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, 32, 1'b1);
    issue(C_REMU, 32'd100, 32'd7, 32'd2, 1'b0, 1'b0, 32, 1'b1);
    issue(C_DIVU, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1, 1'b1);
    issue(C_REMU, 32'd9, 32'd0, 32'd9, 1'b0, 1'b1, 1, 1'b1);

    // 4: request during DIVU is ignored; operand change mid-op has no effect
    issue(C_DIVU, 32'd1000, 32'd10, 32'd100, 1'b0, 1'b0, 32, 1'b1);
    @(negedge clk);
    src1_i  = 32'hDEAD_BEEF;
    src2_i  = 32'h3;
    ctrl_i  = C_AND;
    valid_i = 1'b1;
    repeat (10) @(negedge clk);
    valid_i = 1'b0;

    // 5: reset aborts a MUL in flight
    issue(C_MUL, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 32, 1'b0);
    repeat (10) @(negedge clk);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    chk("abort_ready", {31'd0, ready_o}, 32'd1);
    chk("abort_valid", {31'd0, valid_o}, 32'd0);
    chk("abort_result", result_o, 32'd0);
    issue(C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, 1'b1);
    issue(C_SLTU, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1, 1'b1);

    // 6: branch compare, shifts, LUI
    issue(C_BNE, 32'd3, 32'd3, 32'd0, 1'b0, 1'b0, 1, 1'b1);
    issue(C_BNE, 32'd3, 32'd4, 32'hFFFF_FFFF, 1'b1, 1'b0, 1, 1'b1);
    issue(C_SLL, 32'h21, 32'd1, 32'd2, 1'b0, 1'b0, 1, 1'b1);
    issue(C_SRL, 32'd31, 32'h8000_0000, 32'd1, 1'b0, 1'b0, 1, 1'b1);
    issue(C_LUI, 32'd0, 32'h0000_ABCD, 32'hABCD_0000, 1'b0, 1'b0, 1, 1'b1);

    // Drain and make sure no stray pulses follow.
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (40) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised sequential ALU: the next-generation execute unit for the CPU datapath.
- Supports WIDTH-bit single-cycle logic/arith/shift/compare ops plus iterative unsigned multiply, divide and remainder.
- Uses a valid/ready handshake so the pipeline controller can stall on multi-cycle ops.
- All outputs are registered.

Parameters:
- WIDTH, 32, operand/result width; must be even and at least 8.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- valid_i  in  1  request valid; sampled only when ready_o=1.
- ready_o  out  1  unit can accept a request this cycle.
- src1_i  in  WIDTH  operand A; shift amount is src1_i[$clog2(WIDTH)-1:0].
- src2_i  in  WIDTH  operand B.
- ctrl_i  in  4  operation code, see Behaviour.
- valid_o  out  1  one-cycle pulse: result_o/zero_o/ovf_o are new.
- result_o  out  WIDTH  result; held until next valid_o.
- zero_o  out  1  zero/branch flag; held with result_o.
- ovf_o  out  1  overflow flag; held with result_o.

Behaviour:
- Reset (rst_i=1 at an edge): state=IDLE, ready_o=1, valid_o=0, result_o=0, zero_o=0, ovf_o=0, counter=0.
  - Reset overrides everything, including an op in flight, which is aborted and never reported.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 SLL (src2<<shamt); 0100 LUI (src2<<WIDTH/2).
  - 0101 SRL (src2>>shamt, logical); 0110 SUB (A-B); 0111 SLT (signed, result 1/0).
  - 1000 MUL (low WIDTH bits of unsigned product); 1001 DIVU (quotient); 1010 REMU (remainder).
  - 1110 BNE (computes SUB); 1111 SLTU (unsigned, result 1/0).
  - 1011/1100/1101 reserved: result 0, zero_o=1, ovf_o=0, latency 1.
- Handshake:
  - A request is accepted at an edge where valid_i=1 and ready_o=1.
  - ready_o = (state==IDLE).
  - valid_i while ready_o=0 is ignored. No buffering; the requester must hold or retry.
- Single-cycle ops (all except 1000/1001/1010):
  - Result registered at the accept edge; valid_o=1 in the following cycle.
  - State stays IDLE, so back-to-back accepts give one result per cycle.
- Multi-cycle state machine: IDLE -> MUL or DIV on accept of 1000 or 1001/1010.
  - Operands and opcode are latched at the accept edge; later input changes have no effect.
  - Counter is loaded with WIDTH.
  - One iteration per edge, counter decrements.
  - At the edge where the counter reaches 1: write results, return to IDLE, valid_o=1 next cycle.
  - Latency from accept edge to valid_o is exactly WIDTH cycles; ready_o=0 for WIDTH-1 cycles.
- MUL: shift-add over a 2*WIDTH product register. ovf_o=1 iff the upper WIDTH bits are nonzero.
- DIVU/REMU: restoring shift-subtract, one quotient bit per iteration.
- Divide by zero (src2=0): no iteration, latency 1, stays in IDLE.
  - DIVU result = all ones; REMU result = src1; ovf_o=1.
- Flags:
  - zero_o = (result_o==0) for every op except BNE, where zero_o = (A-B != 0).
  - ovf_o for ADD/SUB/BNE = signed overflow of the WIDTH-bit result; 0 for all other ops except MUL and divide-by-zero.
- valid_o is deasserted in any cycle with no new result. Outputs hold their last values between results.
- Arithmetic wraps modulo 2^WIDTH.
- Shift amount uses only the low $clog2(WIDTH) bits of src1_i; upper bits are ignored.

Decomposition:
- Package alu_pkg holds:
  - 4-bit opcode localparams (OP_AND … OP_SLTU);
  - the state enum (IDLE, MUL, DIV);
  - a function computing single-cycle results.
- One sub-module, alu_iter_muldiv, holds the counter plus the product/remainder/quotient registers. It has a start/done interface and a mode input (mul/div); the top FSM drives it.

Test Plan:
1. Reset, then ADD 0x7FFFFFFF+1 -> valid_o one cycle after accept, result 0x80000000, ovf_o=1, zero_o=0. Back-to-back SUB 5-5 on the next cycle -> result 0, zero_o=1.
2. MUL 0x00010000*0x00010000 -> ready_o low 31 cycles, valid_o 32 cycles after accept, result 0, ovf_o=1, zero_o=1. MUL 1234*5678 -> 7006652, ovf_o=0.
3. DIVU 100/7 -> 14 after 32 cycles. REMU 100/7 -> 2. DIVU 9/0 -> 0xFFFFFFFF, ovf_o=1, latency 1. REMU 9/0 -> 9.
4. Assert valid_i with AND during a DIVU -> ignored; only the DIVU result appears and no extra valid_o pulse. Change src1_i mid-op -> result unaffected.
5. rst_i asserted 10 cycles into a MUL -> next cycle ready_o=1, valid_o=0, result_o=0. A subsequent SLT 0xFFFFFFFF<1 -> 1 and SLTU -> 0.
6. BNE 3,3 -> zero_o=0. BNE 3,4 -> zero_o=1. SLL with src1=0x21, src2=1 -> 2 (shamt=1). SRL with shamt 31 on 0x80000000 -> 1. LUI 0xABCD -> 0xABCD0000.
